// File: rtl/weight_mem_loader_pkg.sv
// Shared types for the weight memory loader.
//   wl_state_e : loader FSM state encoding (IDLE / LOAD / FLUSH)
//   cnt_width  : width of a counter that indexes n items (at least 1 bit)
package weight_mem_loader_pkg;

  typedef enum logic [1:0] {
    WL_IDLE  = 2'd0,
    WL_LOAD  = 2'd1,
    WL_FLUSH = 2'd2
  } wl_state_e;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/weight_mem_loader.sv
// Write-side loader for the per-neuron weight memories of one ELM layer.
// Takes a neuron-major valid/ready stream of weight words and turns each
// accepted word into one write (one-hot wen, shared waddr/wdata) one cycle later.
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   start        pulse: begin a full-layer load (only honoured in IDLE)
//   abort        pulse: cancel a load in progress (only honoured in LOAD)
//   s_valid/s_ready/s_data/s_last   weight word stream
//   wen          one-hot write enable, one bit per neuron memory
//   waddr, wdata write address / data, shared by all memories
//   busy         high while in LOAD
//   done         one-cycle pulse in FLUSH, alongside the final write
//   err          sticky s_last framing error, cleared by start
//   layer_id     constant layer number
//   state_dbg    current FSM state
//
// Handshake: a word is accepted on a rising clock edge where s_valid and
// s_ready are both high. s_ready is a function of FSM state only, never of
// s_valid, and the source must hold s_data/s_last stable while s_valid is high
// and s_ready is low.
module weight_mem_loader
  import weight_mem_loader_pkg::*;
#(
  parameter int layerNo      = 1,
  parameter int numNeurons   = 30,
  parameter int numWeights   = 784,
  parameter int addressWidth = 10,
  parameter int dataWidth    = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [dataWidth-1:0]    s_data,
  input  logic                    s_last,
  output logic [numNeurons-1:0]   wen,
  output logic [addressWidth:0]   waddr,
  output logic [dataWidth-1:0]    wdata,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [7:0]              layer_id,
  output logic [1:0]              state_dbg
);

  localparam int NCW = cnt_width(numNeurons);
  localparam int AW1 = addressWidth + 1;
  localparam logic [AW1-1:0] ACNT_LAST = AW1'(numWeights - 1);
  localparam logic [NCW-1:0] NCNT_LAST = NCW'(numNeurons - 1);

  wl_state_e             state_q, state_d;
  logic [NCW-1:0]        ncnt_q, ncnt_d;
  logic [AW1-1:0]        acnt_q, acnt_d;
  logic [numNeurons-1:0] wen_q, wen_d;
  logic [AW1-1:0]        waddr_q, waddr_d;
  logic [dataWidth-1:0]  wdata_q, wdata_d;
  logic                  err_q, err_d;

  logic accept;
  logic final_word;

  assign accept     = s_valid & s_ready;
  assign final_word = (ncnt_q == NCNT_LAST) && (acnt_q == ACNT_LAST);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= WL_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic. In LOAD, abort beats the final accept: the word is
  // still written but the load ends without a done pulse.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WL_IDLE:  if (start) state_d = WL_LOAD;
      WL_LOAD: begin
        if (abort)                    state_d = WL_IDLE;
        else if (accept && final_word) state_d = WL_FLUSH;
      end
      WL_FLUSH: state_d = WL_IDLE;
      default:  state_d = WL_IDLE;
    endcase
  end

  // FSM outputs, all decoded from state alone
  always_comb begin
    s_ready   = (state_q == WL_LOAD);
    busy      = (state_q == WL_LOAD);
    done      = (state_q == WL_FLUSH);
    state_dbg = state_q;
  end

  // Datapath: counters, write port, error flag
  always_comb begin
    ncnt_d  = ncnt_q;
    acnt_d  = acnt_q;
    wen_d   = '0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    err_d   = err_q;

    if (state_q == WL_IDLE && start) begin
      ncnt_d = '0;
      acnt_d = '0;
      err_d  = 1'b0;
    end

    if (accept) begin
      for (int i = 0; i < numNeurons; i++) begin
        if (ncnt_q == NCW'(i)) wen_d[i] = 1'b1;
      end
      waddr_d = acnt_q;
      wdata_d = s_data;
      // s_last must be high on exactly the final word of the layer
      if (s_last != final_word) err_d = 1'b1;
      if (acnt_q == ACNT_LAST) begin
        acnt_d = '0;
        ncnt_d = final_word ? '0 : ncnt_q + NCW'(1);
      end else begin
        acnt_d = acnt_q + AW1'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ncnt_q  <= '0;
      acnt_q  <= '0;
      wen_q   <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      ncnt_q  <= ncnt_d;
      acnt_q  <= acnt_d;
      wen_q   <= wen_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  assign wen      = wen_q;
  assign waddr    = waddr_q;
  assign wdata    = wdata_q;
  assign err      = err_q;
  assign layer_id = 8'(layerNo);

endmodule

// File: tb/tb_weight_mem_loader.sv
module tb_weight_mem_loader;

  localparam int NN = 2;
  localparam int NW = 4;
  localparam int AW = 10;
  localparam int DW = 16;
  localparam int W  = NN + AW + 1 + DW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          start, abort, s_valid, s_last;
  logic [DW-1:0] s_data;
  logic          s_ready, busy, done, err;
  logic [NN-1:0] wen;
  logic [AW:0]   waddr;
  logic [DW-1:0] wdata;
  logic [7:0]    layer_id;
  logic [1:0]    state_dbg;

  weight_mem_loader #(
    .layerNo(1), .numNeurons(NN), .numWeights(NW), .addressWidth(AW), .dataWidth(DW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .wen(wen), .waddr(waddr), .wdata(wdata), .busy(busy), .done(done),
    .err(err), .layer_id(layer_id), .state_dbg(state_dbg)
  );

  // ---------------- scoreboard ----------------
  int n_vec  = 0;
  int n_miss = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_q[$];
  logic [DW-1:0] mem [NN][NW];
  int done_cnt   = 0;
  int bad_onehot = 0;
  int bad_flush  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  function automatic logic [W-1:0] ew(input int n, input int a, input int d);
    logic [NN-1:0] w;
    w = (n == 0) ? 2'b01 : 2'b10;
    return {w, 11'(a), 16'(d)};
  endfunction

  // Write monitor: samples on the falling edge, away from the active edge
  always @(negedge clk) begin
    if (wen !== '0) begin
      obs_q.push_back({wen, waddr, wdata});
      if (!$onehot(wen)) bad_onehot++;
      if (wen[0]) mem[0][waddr[1:0]] <= wdata;
      if (wen[1]) mem[1][waddr[1:0]] <= wdata;
    end
    if (done === 1'b1) begin
      done_cnt++;
      if (s_ready !== 1'b0 || busy !== 1'b0) bad_flush++;
    end
  end

  task automatic drain(input string tag);
    logic [W-1:0] o, e;
    check({tag, "_nwrites"}, obs_q.size(), exp_q.size());
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      check({tag, "_write"}, 32'(o), 32'(e));
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input int d, input bit last);
    bit ok;
    ok = 1'b0;
    s_valid = 1'b1;
    s_data  = 16'(d);
    s_last  = last;
    for (int i = 0; i < 16 && !ok; i++) begin
      @(negedge clk);
      if (s_ready === 1'b1) ok = 1'b1;
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    if (!ok) check("accept_timeout", 0, 1);
  endtask

  // Full 8-word layer: word k goes to neuron (k-1)/4, address (k-1)%4
  task automatic send_layer(input int base, input int extra_last, input int gap);
    for (int k = 1; k <= 8; k++) begin
      exp_q.push_back(ew((k - 1) / NW, (k - 1) % NW, base + k));
      send(base + k, (k == 8) || (k == extra_last));
      if (gap > 0) idle(gap);
    end
  endtask

  // ---------------- stimulus ----------------
  int d0;

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    s_valid = 1'b0; s_last = 1'b0; s_data = '0;
    #2;
    check("rst_ready", s_ready, 0);
    check("rst_wen",   wen, 0);
    check("rst_waddr", waddr, 0);
    check("rst_wdata", wdata, 0);
    check("rst_busy",  busy, 0);
    check("rst_done",  done, 0);
    check("rst_err",   err, 0);
    check("layer_id",  layer_id, 1);
    #20;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: back-to-back full layer
    d0 = done_cnt;
    pulse_start();
    check("t1_busy", busy, 1);
    send_layer(16'h0000, 0, 0);
    idle(4);
    drain("t1");
    check("t1_done", done_cnt - d0, 1);
    check("t1_err", err, 0);
    check("t1_idle_busy", busy, 0);

    // 2: s_valid every other cycle
    d0 = done_cnt;
    pulse_start();
    send_layer(16'h0030, 0, 1);
    idle(4);
    drain("t2");
    check("t2_done", done_cnt - d0, 1);
    check("t2_err", err, 0);

    // 3: early s_last on word 3 -> sticky err, load still completes
    d0 = done_cnt;
    pulse_start();
    for (int k = 1; k <= 3; k++) begin
      exp_q.push_back(ew(0, k - 1, 16'h40 + k));
      send(16'h40 + k, k == 3);
    end
    @(negedge clk);
    check("t3_err_set", err, 1);
    @(posedge clk); #1;
    for (int k = 4; k <= 8; k++) begin
      exp_q.push_back(ew((k - 1) / NW, (k - 1) % NW, 16'h40 + k));
      send(16'h40 + k, k == 8);
    end
    idle(4);
    drain("t3");
    check("t3_done", done_cnt - d0, 1);
    check("t3_err_sticky", err, 1);

    // 4: start clears err; abort coinciding with 5th accept
    d0 = done_cnt;
    pulse_start();
    check("t4_err_clr", err, 0);
    for (int k = 1; k <= 5; k++) begin
      exp_q.push_back(ew((k - 1) / NW, (k - 1) % NW, 16'h50 + k));
      if (k == 5) abort = 1'b1;
      send(16'h50 + k, 1'b0);
      abort = 1'b0;
    end
    idle(3);
    drain("t4a");
    check("t4_abort_busy", busy, 0);
    check("t4_abort_ready", s_ready, 0);
    check("t4_no_done", done_cnt - d0, 0);
    pulse_start();
    send_layer(16'h0020, 0, 0);
    idle(4);
    drain("t4b");
    check("t4_done", done_cnt - d0, 1);

    // 5: reset after 3 accepts; the 3rd write is cut off by reset
    d0 = done_cnt;
    pulse_start();
    for (int k = 1; k <= 3; k++) begin
      if (k < 3) exp_q.push_back(ew(0, k - 1, 16'h70 + k));
      send(16'h70 + k, 1'b0);
    end
    rst_n = 1'b0;
    #1;
    check("t5_wen",   wen, 0);
    check("t5_waddr", waddr, 0);
    check("t5_wdata", wdata, 0);
    check("t5_ready", s_ready, 0);
    check("t5_busy",  busy, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    drain("t5a");
    pulse_start();
    send_layer(16'h0010, 0, 0);
    idle(4);
    drain("t5b");
    check("t5_done", done_cnt - d0, 1);
    check("t5_err", err, 0);

    // 6: start during LOAD is ignored
    d0 = done_cnt;
    pulse_start();
    for (int k = 1; k <= 8; k++) begin
      exp_q.push_back(ew((k - 1) / NW, (k - 1) % NW, 16'h60 + k));
      send(16'h60 + k, k == 8);
      if (k == 3) pulse_start();
    end
    idle(4);
    drain("t6");
    check("t6_done", done_cnt - d0, 1);
    check("t6_err", err, 0);
    for (int n = 0; n < NN; n++)
      for (int a = 0; a < NW; a++)
        check($sformatf("mem_n%0d_a%0d", n, a), mem[n][a], 16'h61 + n * NW + a);

    check("wen_onehot", bad_onehot, 0);
    check("flush_ready_busy", bad_flush, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
